// File: rtl/iq_axis_packer.sv
// iq_axis_packer
// Packs one overlay I/Q channel pair into {Q,I} words, buffers them in a small
// FIFO and streams them to the PS DMA as AXI4-Stream frames with TLAST.
// On disable the FIFO is drained and the open frame is always closed, either
// by tagging the last buffered word or by emitting a zero pad word.
module iq_axis_packer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_enable,
  input  logic signed [DATA_W-1:0] i_I_data,
  input  logic signed [DATA_W-1:0] i_Q_data,
  input  logic                     i_I_valid,
  input  logic                     i_Q_valid,
  output logic [2*DATA_W-1:0]      m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     o_overflow,
  output logic [15:0]              o_overflow_count,
  output logic                     o_busy
);

  localparam int WORD_W = 2 * DATA_W;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = AW + 1;
  localparam int FC_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [FC_W-1:0]  LAST_POS = FC_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Packs a sample pair with I in the low half of the word.
  function automatic logic [WORD_W-1:0] pack_iq(input logic signed [DATA_W-1:0] i_s,
                                                input logic signed [DATA_W-1:0] q_s);
    return {q_s, i_s};
  endfunction

  // Saturating increment for the drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t state_q, state_d;

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic              out_vld_q, out_vld_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       ovf_cnt_q, ovf_cnt_d;

  logic              hs;
  logic              stage_free;
  logic              accept;
  logic [CNT_W-1:0]  occupancy;
  logic              full;
  logic              wr_en;
  logic              drop;
  logic              draining;
  logic              rd_en;
  logic              pad_en;
  logic [FC_W-1:0]   ld_pos;
  logic              ld_last;
  logic              drain_done;

  // Handshake, FIFO and framing control decoded from the registered state.
  always_comb begin
    hs         = out_vld_q & m_axis_tready;
    stage_free = ~out_vld_q | m_axis_tready;
    accept     = (state_q == ST_RUN) & i_enable & i_I_valid & i_Q_valid;
    // The output stage counts as buffer space, so capacity is FIFO_DEPTH words in total.
    occupancy  = fifo_cnt_q + {{AW{1'b0}}, out_vld_q};
    full       = (occupancy == DEPTH_C);
    wr_en      = accept & ~full;
    drop       = accept & full;
    // A disable seen in RUN already closes the frame on the word loaded at that edge.
    draining   = (state_q == ST_DRAIN) | ((state_q == ST_RUN) & ~i_enable);
    rd_en      = stage_free & (fifo_cnt_q != '0);
    pad_en     = (state_q == ST_DRAIN) & (fifo_cnt_q == '0) & ~out_vld_q &
                 (frame_cnt_q != '0);
    // Frame position of the word about to enter the output stage.
    if (out_vld_q) begin
      ld_pos = out_last_q ? '0 : FC_W'(frame_cnt_q + 1'b1);
    end else begin
      ld_pos = frame_cnt_q;
    end
    ld_last    = (ld_pos == LAST_POS) | (draining & (fifo_cnt_q == CNT_W'(1)));
    drain_done = (fifo_cnt_q == '0) &
                 (out_vld_q ? (m_axis_tready & out_last_q) : (frame_cnt_q == '0));
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_enable)   state_d = ST_RUN;
      ST_RUN:   if (!i_enable)  state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_busy = (state_q != ST_IDLE);
  end

  // Next values for FIFO pointers, output stage, frame counter and drop stats.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    frame_cnt_d = frame_cnt_q;
    ovf_d       = ovf_q;
    ovf_cnt_d   = ovf_cnt_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    if (rd_en) begin
      out_vld_d  = 1'b1;
      out_data_d = mem_q[rd_ptr_q];
      out_last_d = ld_last;
    end else if (pad_en) begin
      out_vld_d  = 1'b1;
      out_data_d = '0;
      out_last_d = 1'b1;
    end else if (hs) begin
      out_vld_d  = 1'b0;
    end

    if (hs) begin
      frame_cnt_d = out_last_q ? '0 : FC_W'(frame_cnt_q + 1'b1);
    end

    if (drop) begin
      ovf_d     = 1'b1;
      ovf_cnt_d = sat_inc16(ovf_cnt_q);
    end
  end

  // Sample storage; contents need no reset because the count gates every read.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= pack_iq(i_I_data, i_Q_data);
  end

  // State, control and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign m_axis_tdata     = out_data_q;
  assign m_axis_tvalid    = out_vld_q;
  assign m_axis_tlast     = out_last_q;
  assign o_overflow       = ovf_q;
  assign o_overflow_count = ovf_cnt_q;

endmodule

// File: doc/iq_axis_packer.md
Name: iq_axis_packer

Overview:
- Sits directly downstream of the overlay: consumes one overlay output channel pair (o_I*/o_Q* data plus valid strobes).
- Packs each I/Q pair into a 32-bit word and buffers it in a small FIFO.
- Emits the words as an AXI4-Stream master with TLAST framing for the PS DMA.
- Handles enable/disable cleanly: on disable, drains the FIFO and always closes the open frame so the DMA never hangs.

Parameters:
- DATA_W, 16, width of each I and Q sample.
- FIFO_DEPTH, 16, number of packed words buffered; power of 2, minimum 4.
- FRAME_LEN, 256, words per AXI-Stream frame; TLAST is asserted on word FRAME_LEN.

Ports:
- i_clk  in  1  system clock; the only clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  capture enable.
- i_I_data  in  DATA_W  I sample, signed.
- i_Q_data  in  DATA_W  Q sample, signed.
- i_I_valid  in  1  I sample strobe.
- i_Q_valid  in  1  Q sample strobe.
- m_axis_tdata  out  2*DATA_W  packed word: {Q,I}, with I in the low half.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tlast  out  1  end of frame.
- o_overflow  out  1  sticky flag: a sample was dropped.
- o_overflow_count  out  16  count of dropped samples; saturates at 0xFFFF.
- o_busy  out  1  high when state is not IDLE.

Behaviour:
- Reset: every output is 0; state IDLE, FIFO empty, frame counter 0, overflow count and flag cleared.
  - Reset mid-operation discards FIFO contents.
  - No TLAST is produced for a truncated frame.
- Accept rule: a sample is accepted on a rising edge where i_I_valid & i_Q_valid & i_enable are all 1 and state is RUN.
  - If only one valid is high, the sample is ignored and nothing is counted.
- FIFO write rule:
  - An accepted sample is written if the FIFO is not full.
  - If the FIFO is full, the sample is dropped, o_overflow_count increments (saturating) and o_overflow is set.
  - Fullness uses the registered count, so a sample arriving on the same edge as a read while full is still dropped.
- Output path:
  - First-word-fall-through with a registered output stage.
  - Latency: a word accepted at edge N, with the FIFO and output stage empty, has tvalid=1 after edge N+1.
  - Sustains 1 word/cycle when m_axis_tready is held 1.
  - AXI rules: once tvalid=1, tdata and tlast stay stable and tvalid stays high until tready=1.
- Frame counter:
  - Counts output handshakes (tvalid & tready).
  - tlast=1 on the word where count == FRAME_LEN-1; the counter then wraps to 0.
  - Dropped samples are never counted.
- State machine:
  - IDLE: no output. On i_enable=1 go to RUN; frame counter is 0 at this point.
  - RUN: accepts samples. On i_enable=0 go to DRAIN; a sample presented on that same edge is not accepted.
  - DRAIN: no writes; the FIFO keeps emptying.
    - The last word leaving the FIFO carries tlast=1 even if the frame is short; the counter then resets to 0.
    - If the FIFO is already empty and the frame counter is nonzero, emit one pad word 0x00000000 with tlast=1.
    - If the FIFO is empty and the frame counter is 0, emit no pad.
    - Return to IDLE after the final handshake, or immediately when there is nothing to send.
    - i_enable re-asserting during DRAIN is ignored until IDLE is reached.
- Overflow counter and flag are cleared only by reset.

Test Plan:
- FRAME_LEN=4, tready=1, enable, 4 pairs I=0x0001..0x0004, Q=0x8001..0x8004 -> words 0x80010001..0x80040004; first tvalid one cycle after the first accept; tlast only on 0x80040004.
- tready=0, 20 consecutive pairs, FIFO_DEPTH=16 -> 16 stored, o_overflow_count=4, o_overflow=1; then tready=1 -> the first 16 words emitted in order, with tdata held stable while stalled.
- FRAME_LEN=4, 6 pairs, then i_enable=0 -> words 1-4 (tlast on 4), words 5-6 (tlast on 6); o_busy falls after word 6.
- FRAME_LEN=4, 5 pairs fully drained, then i_enable=0 -> one pad word 0x00000000 with tlast=1. Exactly 4 pairs drained, then disable -> no pad; IDLE within 1 cycle.
- i_I_valid=1 with i_Q_valid=0 for 10 cycles, and separately valid pairs while i_enable=0 -> no tvalid, overflow count unchanged.
- Assert i_rst_n=0 mid-frame with 3 words queued and tready=0 -> tvalid, tlast, o_busy and counters are 0 immediately (asynchronous); after release, a new enable starts a clean frame.
